// File: rtl/node_membank_ctrl_pkg.sv
// Shared types and helpers for the node memory bank.
// State codes and byte-lane address arithmetic.
package node_membank_ctrl_pkg;

  localparam int BYTE_W_DEF = 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Byte address of lane k, wrapped into a power-of-two array
  function automatic int unsigned lane_addr(
    int unsigned base,
    int unsigned k,
    int unsigned depth
  );
    return (base + k) & (depth - 1);
  endfunction

  // Lane k falls past the top of the array
  function automatic logic lane_oob(
    int unsigned base,
    int unsigned k,
    int unsigned depth
  );
    return (base + k) >= depth;
  endfunction

endpackage

// File: rtl/node_membank_ctrl_if.sv
// Request/response bundle for the node memory bank.
// Master issues requests and consumes responses.
interface node_membank_ctrl_if #(
  parameter int BYTE_W     = 8,
  parameter int WORD_BYTES = 2,
  parameter int ADDR_W     = 6
);
  localparam int DW = WORD_BYTES * BYTE_W;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DW-1:0]         req_wdata;
  logic [WORD_BYTES-1:0] req_be;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DW-1:0]         rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_err
  );

endinterface

// File: rtl/node_membank_array.sv
// Byte-wide storage with per-lane write enables,
// combinational read lanes and a clear write port.
module node_membank_array #(
  parameter int BYTE_W     = 8,
  parameter int WORD_BYTES = 2,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              clr_we,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [WORD_BYTES-1:0] lane_we,
  input  logic [ADDR_W-1:0] lane_addr  [WORD_BYTES],
  input  logic [BYTE_W-1:0] lane_wdata [WORD_BYTES],
  output logic [BYTE_W-1:0] lane_rdata [WORD_BYTES]
);

  logic [BYTE_W-1:0] mem_q [DEPTH];

  // Sweep zeroes one byte; request lanes write selected bytes
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end
    for (int k = 0; k < WORD_BYTES; k++) begin
      if (lane_we[k]) begin
        mem_q[lane_addr[k]] <= lane_wdata[k];
      end
    end
  end

  // Each lane reads its own byte address
  always_comb begin
    for (int k = 0; k < WORD_BYTES; k++) begin
      lane_rdata[k] = mem_q[lane_addr[k]];
    end
  end

endmodule

// File: rtl/node_membank_ctrl.sv
// Node memory bank: clear sweep, byte-enabled writes,
// registered big-endian reads with out-of-bounds flagging.
module node_membank_ctrl
  import node_membank_ctrl_pkg::*;
#(
  parameter int BYTE_W     = BYTE_W_DEF,
  parameter int WORD_BYTES = 2,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 6,
  parameter int WRAP       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  node_membank_ctrl_if.slave bus,
  output logic busy,
  output logic err_oob
);

  localparam int DW = WORD_BYTES * BYTE_W;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic              err_oob_q, err_oob_d;

  logic [ADDR_W-1:0]     lane_a  [WORD_BYTES];
  logic [BYTE_W-1:0]     lane_wd [WORD_BYTES];
  logic [BYTE_W-1:0]     lane_rd [WORD_BYTES];
  logic [WORD_BYTES-1:0] lane_bad;
  logic [WORD_BYTES-1:0] lane_we;
  logic [DW-1:0]         rword;
  logic                  oob;
  logic                  ready;
  logic                  accept;
  logic                  clr_we;

  assign oob    = |lane_bad;
  assign ready  = (state_q == ST_READY) && !clr &&
                  (!rsp_valid_q || bus.rsp_ready);
  assign accept = ready && bus.req_valid;
  assign clr_we = (state_q == ST_CLEAR);

  // Map word lanes (lane 0 = MSB) onto array bytes
  always_comb begin
    rword    = '0;
    lane_bad = '0;
    lane_we  = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      lane_a[k] = ADDR_W'(lane_addr(
        32'(bus.req_addr), 32'(k), DEPTH));
      lane_bad[k] = (WRAP == 0) && lane_oob(
        32'(bus.req_addr), 32'(k), DEPTH);
      lane_wd[k] =
        bus.req_wdata[(WORD_BYTES-1-k)*BYTE_W +: BYTE_W];
      rword[(WORD_BYTES-1-k)*BYTE_W +: BYTE_W] =
        lane_bad[k] ? '0 : lane_rd[k];
    end
    for (int k = 0; k < WORD_BYTES; k++) begin
      lane_we[k] = accept && bus.req_we && !oob &&
                   bus.req_be[WORD_BYTES-1-k];
    end
  end

  // Sweep sequencing and response register update
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    err_oob_d   = accept && oob;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
    if (rsp_valid_q && bus.rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
    if (accept && !bus.req_we) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = rword;
      rsp_err_d   = oob;
    end
  end

  // State registers; reset restarts the sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_oob_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      err_oob_q   <= err_oob_d;
    end
  end

  node_membank_array #(
    .BYTE_W     (BYTE_W),
    .WORD_BYTES (WORD_BYTES),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_array (
    .clk        (clk),
    .clr_we     (clr_we),
    .clr_addr   (cnt_q),
    .lane_we    (lane_we),
    .lane_addr  (lane_a),
    .lane_wdata (lane_wd),
    .lane_rdata (lane_rd)
  );

  assign bus.req_ready = ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = clr_we;
  assign err_oob       = err_oob_q;

endmodule

// File: tb/tb_node_membank_ctrl.sv
// Bench for node_membank_ctrl: a wrapping and a non-wrapping
// instance share stimulus and are checked against a byte model.
module tb_node_membank_ctrl;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        req_valid;
  logic        req_we;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  req_be;
  logic        rsp_ready;
  logic        busy_w, busy_n, oob_w, oob_n;

  int total = 0;
  int bad   = 0;

  node_membank_ctrl_if #(.BYTE_W(8), .WORD_BYTES(2), .ADDR_W(6)) bw ();
  node_membank_ctrl_if #(.BYTE_W(8), .WORD_BYTES(2), .ADDR_W(6)) bn ();

  assign bw.req_valid = req_valid;
  assign bw.req_we    = req_we;
  assign bw.req_addr  = req_addr;
  assign bw.req_wdata = req_wdata;
  assign bw.req_be    = req_be;
  assign bw.rsp_ready = rsp_ready;
  assign bn.req_valid = req_valid;
  assign bn.req_we    = req_we;
  assign bn.req_addr  = req_addr;
  assign bn.req_wdata = req_wdata;
  assign bn.req_be    = req_be;
  assign bn.rsp_ready = rsp_ready;

  node_membank_ctrl #(.WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .bus(bw),
    .busy(busy_w), .err_oob(oob_w)
  );

  node_membank_ctrl #(.WRAP(0)) u_nowrap (
    .clk(clk), .rst(rst), .clr(clr), .bus(bn),
    .busy(busy_n), .err_oob(oob_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mw [64];
  logic [7:0]  mn [64];
  int          left;
  bit          m_rv;
  logic [15:0] m_dw, m_dn;
  bit          m_en;
  bit          m_oob;

  always @(negedge clk) begin : cmp
    bit          e_busy, e_rdy, acc, o;
    int          a, ad;
    logic [15:0] dw, dn;
    logic [7:0]  b;
    if (rst) begin
      chk("rst_busy_w", busy_w, 1);
      chk("rst_busy_n", busy_n, 1);
      chk("rst_ready", bw.req_ready, 0);
      chk("rst_rv_w", bw.rsp_valid, 0);
      chk("rst_rv_n", bn.rsp_valid, 0);
      chk("rst_data", bw.rsp_data, 0);
      chk("rst_err", bn.rsp_err, 0);
      chk("rst_oob", oob_n, 0);
      left = 64; m_rv = 0; m_dw = 0; m_dn = 0;
      m_en = 0; m_oob = 0;
    end else begin
      e_busy = left > 0;
      e_rdy  = !e_busy && !clr && (!m_rv || rsp_ready);
      chk("busy_w", busy_w, e_busy);
      chk("busy_n", busy_n, e_busy);
      chk("ready_w", bw.req_ready, e_rdy);
      chk("ready_n", bn.req_ready, e_rdy);
      chk("rv_w", bw.rsp_valid, m_rv);
      chk("rv_n", bn.rsp_valid, m_rv);
      chk("oob_w", oob_w, 0);
      chk("oob_n", oob_n, m_oob);
      if (m_rv) begin
        chk("data_w", bw.rsp_data, m_dw);
        chk("data_n", bn.rsp_data, m_dn);
        chk("err_w", bw.rsp_err, 0);
        chk("err_n", bn.rsp_err, m_en);
      end
      acc = e_rdy && req_valid;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          for (int i = 0; i < 64; i++) begin
            mw[i] = 0; mn[i] = 0;
          end
        end
      end else if (clr) begin
        left = 64;
      end
      if (m_rv && rsp_ready) m_rv = 0;
      m_oob = 0;
      if (acc) begin
        a = int'(req_addr);
        o = (a + 1) >= 64;
        dw = 0; dn = 0;
        for (int k = 0; k < 2; k++) begin
          ad = (a + k) % 64;
          b  = req_wdata[(1-k)*8 +: 8];
          if (req_we) begin
            if (req_be[1-k]) begin
              mw[ad] = b;
              if (!o) mn[ad] = b;
            end
          end else begin
            dw[(1-k)*8 +: 8] = mw[ad];
            dn[(1-k)*8 +: 8] = (a + k < 64) ? mn[ad] : 8'h00;
          end
        end
        if (!req_we) begin
          m_rv = 1; m_dw = dw; m_dn = dn; m_en = o;
        end
        m_oob = o;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_req(bit we, logic [5:0] a,
                        logic [15:0] d, logic [1:0] be);
    bit acc = 0;
    req_valid = 1; req_we = we; req_addr = a;
    req_wdata = d; req_be = be;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = bw.req_ready;
      step();
    end
    req_valid = 0;
    chk("req_accept", acc, 1);
  endtask

  task automatic read_exp(logic [5:0] a, logic [15:0] ew,
                          logic [15:0] en, bit ee);
    do_req(0, a, 16'h0, 2'b00);
    @(negedge clk);
    chk("rd_valid", bw.rsp_valid, 1);
    chk("rd_lit_w", bw.rsp_data, ew);
    chk("rd_lit_n", bn.rsp_data, en);
    chk("rd_lit_err", bn.rsp_err, ee);
    step();
  endtask

  task automatic count_busy();
    int n = 0;
    @(negedge clk);
    while (busy_w && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, 64);
    step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1; clr = 0; req_valid = 0; req_we = 0;
    req_addr = 0; req_wdata = 0; req_be = 0; rsp_ready = 1;
    repeat (3) step();
    rst = 0;
    count_busy();

    read_exp(6'h10, 16'h0000, 16'h0000, 0);

    do_req(1, 6'h04, 16'hBEEF, 2'b11);
    read_exp(6'h04, 16'hBEEF, 16'hBEEF, 0);
    read_exp(6'h05, 16'hEF00, 16'hEF00, 0);

    do_req(1, 6'h08, 16'h1234, 2'b11);
    do_req(1, 6'h08, 16'hAB00, 2'b10);
    read_exp(6'h08, 16'hAB34, 16'hAB34, 0);

    do_req(1, 6'h3F, 16'hCAFE, 2'b11);
    @(negedge clk);
    chk("oob_pulse_n", oob_n, 1);
    chk("oob_pulse_w", oob_w, 0);
    step();
    read_exp(6'h3F, 16'hCAFE, 16'h0000, 1);
    read_exp(6'h00, 16'hFE00, 16'h0000, 0);
    do_req(1, 6'h3E, 16'h0077, 2'b01);
    read_exp(6'h3F, 16'h77FE, 16'h7700, 1);

    // backpressure, then consume and accept in one cycle
    rsp_ready = 0;
    do_req(0, 6'h04, 16'h0, 2'b00);
    req_valid = 1; req_we = 0; req_addr = 6'h08;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", bw.rsp_valid, 1);
      chk("bp_data", bw.rsp_data, 16'hBEEF);
      chk("bp_ready", bw.req_ready, 0);
      step();
    end
    rsp_ready = 1;
    @(negedge clk);
    chk("bp_accept", bw.req_ready, 1);
    step();
    req_valid = 0;
    @(negedge clk);
    chk("bp_next_valid", bw.rsp_valid, 1);
    chk("bp_next_data", bw.rsp_data, 16'hAB34);
    step();

    // clr beats a same-cycle write
    clr = 1; req_valid = 1; req_we = 1; req_addr = 6'h04;
    req_wdata = 16'h1111; req_be = 2'b11;
    @(negedge clk);
    chk("clr_blocks", bw.req_ready, 0);
    step();
    clr = 0; req_valid = 0;
    count_busy();
    read_exp(6'h04, 16'h0000, 16'h0000, 0);

    // pending response survives into the sweep
    rsp_ready = 0;
    do_req(0, 6'h08, 16'h0, 2'b00);
    clr = 1;
    step();
    clr = 0;
    repeat (3) step();
    @(negedge clk);
    chk("clr_rsp_held", bw.rsp_valid, 1);
    chk("clr_busy", busy_w, 1);
    step();
    rsp_ready = 1;
    step();
    @(negedge clk);
    chk("clr_rsp_gone", bw.rsp_valid, 0);
    step();

    // reset mid-sweep restarts it
    repeat (10) step();
    rst = 1;
    repeat (2) step();
    rst = 0;
    count_busy();

    // reset drops a pending response
    rsp_ready = 0;
    do_req(0, 6'h04, 16'h0, 2'b00);
    rst = 1;
    @(negedge clk);
    chk("rst_drop_rsp", bw.rsp_valid, 0);
    step();
    rst = 0;
    count_busy();
    rsp_ready = 1;
    read_exp(6'h3F, 16'h0000, 16'h0000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/node_membank_ctrl.md
Name: node_membank_ctrl

Overview:
Parametrised byte-addressed node memory bank for the EER-RL node datapath; stores per-node state (energy, Q-values, hop counts) as big-endian multi-byte words at arbitrary byte offsets. Generalises the fixed 16-bit/64-byte bank with configurable word width and depth, byte enables, a valid/ready request/response handshake, a registered read port, a hardware clear sequencer and out-of-bounds handling. Sits between the node controller FSM and the RL update unit.

Parameters:
BYTE_W, 8, bits per memory byte
WORD_BYTES, 2, bytes per access word (1..8)
DEPTH, 64, bytes in array; power of two
ADDR_W, 6, log2(DEPTH)
WRAP, 1, 1 = accesses crossing the top address wrap modulo DEPTH; 0 = flagged out-of-bounds

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
clr  in  1  request full-array zero sweep
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  byte address of MSB byte
req_wdata  in  WORD_BYTES*BYTE_W  write word, MSB byte first
req_be  in  WORD_BYTES  byte enables, bit WORD_BYTES-1 = MSB byte
rsp_valid  out  1  read data valid
rsp_ready  in  1  consumer takes rsp_data
rsp_data  out  WORD_BYTES*BYTE_W  read word
rsp_err  out  1  response carries out-of-bounds flag
busy  out  1  clear sweep in progress
err_oob  out  1  one-cycle pulse on any out-of-bounds request accepted

Behaviour:
- Reset (async, rst=1): state=CLEAR, clear counter=0, rsp_valid=0, rsp_data=0, rsp_err=0, err_oob=0, req_ready=0, busy=1. Array contents not reset directly; cleared by the sweep.
- FSM states: CLEAR, READY.
- CLEAR: writes zero to byte[cnt] each cycle, cnt increments; after cnt=DEPTH-1 moves to READY. Sweep takes exactly DEPTH cycles; busy=1, req_ready=0 throughout.
- READY: req_ready = !rsp_valid | rsp_ready. clr=1 in READY -> CLEAR next cycle, counter=0; clr has priority over a same-cycle request (request not accepted, req_ready forced 0 when clr=1). A pending response is kept and still deliverable during CLEAR.
- Byte mapping: byte k (k=0 MSB) of a word lives at (req_addr+k) mod DEPTH when WRAP=1.
- WRAP=0: request is OOB if req_addr+WORD_BYTES-1 >= DEPTH. OOB write: no bytes written. OOB read: in-range bytes returned, out-of-range bytes read 0, rsp_err=1. err_oob pulses 1 cycle on acceptance of any OOB request. WRAP=1: never OOB.
- Write: on accept, byte k written iff req_be[WORD_BYTES-1-k]=1; takes effect at the accepting edge. No response generated.
- Read: on accept, rsp_data/rsp_err registered at the same edge; rsp_valid=1 next cycle (latency 1). Held stable until rsp_valid&rsp_ready. Simultaneous consume and new read accept: rsp_valid stays 1 with new data.
- Read after write to overlapping bytes on consecutive cycles returns new data (array updated at accepting edge). Same-cycle collision impossible: single request port.
- Reset mid-sweep or mid-response: sweep restarts from 0, response discarded.
- req_be ignored for reads.

Decomposition:
- Shared package: FSM state encoding (ST_CLEAR, ST_READY), BYTE_W default, helper function for wrapped/OOB byte address computation.
- One sub-module natural: node_membank_array (byte array, per-byte write enables, WORD_BYTES combinational read lanes with modulo addressing); controller FSM, clear counter and response register stay in the top.

Test Plan:
- Reset release -> busy=1 for exactly 64 cycles, req_ready=0, then READY; read addr 0x10 -> rsp_data=0x0000, rsp_err=0.
- Write addr 0x04 data 0xBEEF be=2'b11, read addr 0x04 next cycle -> 0xBEEF one cycle after accept; read addr 0x05 -> 0xEF00.
- Write addr 0x08 0x1234 be=11, then write 0x08 0xAB00 be=10, read 0x08 -> 0xAB34.
- WRAP=1: write addr 0x3F 0xCAFE -> byte[0x3F]=0xCA, byte[0x00]=0xFE, read 0x3F -> 0xCAFE. WRAP=0: same write -> err_oob pulse, memory unchanged; read 0x3F -> 0x0000 with rsp_err=1 after preloading byte[0x3F]=0x00.
- Backpressure: read 0x04 with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_data 0xBEEF stable, req_ready=0; rsp_ready=1 with new read 0x08 same cycle -> next rsp 0xAB34, no bubble.
- clr asserted in READY with req_valid=1 -> request not accepted, busy=1 for 64 cycles, then read 0x04 -> 0x0000; rst asserted mid-sweep -> sweep restarts, busy for full 64 cycles.
